// File: rtl/pipelined_divider_param.sv
// Fully pipelined restoring divider: one operation per cycle and one result
// per cycle, in order. Operand width is W and the sideband tag is TAG_W bits.
// Stages: S0 (operand magnitudes and flags), S1..SW (one quotient bit each,
// MSB first), SO (sign fix and special cases, registered onto the outputs).
// The whole pipe advances on en = !out_valid || out_ready, otherwise it holds.
module pipelined_divider_param #(
  parameter int W     = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [W-1:0]     in_dividend,
  input  logic [W-1:0]     in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_quotient,
  output logic [W-1:0]     out_remainder,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_zero,
  output logic             out_overflow
);

  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};

  // Contents of one pipeline stage. rq holds remainder (upper half) and
  // quotient (lower half); the quotient half initially holds the dividend
  // magnitude and is shifted out one bit per iteration stage.
  typedef struct packed {
    logic             v;
    logic [2*W-1:0]   rq;
    logic [W-1:0]     dmag;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             ov;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic   en;
  stage_t stage_q [0:W];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------------
  // S0: magnitudes, sign flags, special-case detection
  // ---------------------------------------------------------------------
  logic   dividend_neg;
  logic   divisor_neg;
  stage_t s0_next;
  stage_t s0_reg;

  // Build the S0 contents from the input operation.
  always_comb begin
    dividend_neg  = in_signed && in_dividend[W-1];
    divisor_neg   = in_signed && in_divisor[W-1];
    s0_next.v     = in_valid;
    s0_next.rq    = {{W{1'b0}}, (dividend_neg ? -in_dividend : in_dividend)};
    s0_next.dmag  = divisor_neg ? -in_divisor : in_divisor;
    s0_next.neg_q = dividend_neg ^ divisor_neg;
    s0_next.neg_r = dividend_neg;
    s0_next.dz    = (in_divisor == '0);
    s0_next.ov    = in_signed && (in_dividend == MOST_NEG) && (in_divisor == ALL_ONES);
    s0_next.tag   = in_tag;
  end

  // S0 register: cleared by reset, loaded whenever the pipe advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_reg <= '0;
    end else if (en) begin
      s0_reg <= s0_next;
    end
  end

  assign stage_q[0] = s0_reg;

  // ---------------------------------------------------------------------
  // S1..SW: restoring iterations, one quotient bit per stage
  // ---------------------------------------------------------------------
  for (genvar gi = 1; gi <= W; gi++) begin : g_iter
    stage_t     cur;
    stage_t     nxt;
    stage_t     iter_reg;
    logic [W:0] trial;

    // Shift {rem, quo} left and try subtracting the divisor. The trial uses
    // the W+1-bit shifted remainder, so the bit shifted out of the remainder
    // half takes part in the comparison.
    always_comb begin
      cur   = stage_q[gi-1];
      trial = cur.rq[2*W-1:W-1] - {1'b0, cur.dmag};
      nxt   = cur;
      if (!trial[W]) begin
        nxt.rq = {trial[W-1:0], cur.rq[W-2:0], 1'b1};
      end else begin
        nxt.rq = {cur.rq[2*W-2:0], 1'b0};
      end
    end

    // Iteration stage register.
    always_ff @(posedge clk) begin
      if (rst) begin
        iter_reg <= '0;
      end else if (en) begin
        iter_reg <= nxt;
      end
    end

    assign stage_q[gi] = iter_reg;
  end

  // ---------------------------------------------------------------------
  // SO: sign fix and special-case override
  // ---------------------------------------------------------------------
  logic [W-1:0] q_raw;
  logic [W-1:0] r_raw;
  logic [W-1:0] q_fix;
  logic [W-1:0] r_fix;

  // Apply result signs, then override for divide-by-zero and overflow.
  // With a zero divisor every trial succeeds, so the remainder half ends up
  // holding the dividend magnitude; re-applying the dividend sign restores
  // the original dividend bit pattern.
  always_comb begin
    q_raw = stage_q[W].rq[W-1:0];
    r_raw = stage_q[W].rq[2*W-1:W];
    q_fix = stage_q[W].neg_q ? -q_raw : q_raw;
    r_fix = stage_q[W].neg_r ? -r_raw : r_raw;
    if (stage_q[W].dz) begin
      q_fix = ALL_ONES;
    end else if (stage_q[W].ov) begin
      q_fix = MOST_NEG;
      r_fix = '0;
    end
  end

  // Output registers; they hold while a result waits for out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_div_zero  <= 1'b0;
      out_overflow  <= 1'b0;
    end else if (en) begin
      out_valid     <= stage_q[W].v;
      out_quotient  <= q_fix;
      out_remainder <= r_fix;
      out_tag       <= stage_q[W].tag;
      out_div_zero  <= stage_q[W].dz;
      out_overflow  <= stage_q[W].ov;
    end
  end

endmodule

// File: tb/tb_pipelined_divider_param.sv
// Bench for pipelined_divider_param: directed table at W=16, reset mid-flight,
// random streaming with backpressure against a scoreboard, and W=8 / W=32
// instances for latency and special cases.
module tb_pipelined_divider_param;

  localparam int W     = 16;
  localparam int TAG_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_signed = 1'b0;
  logic [15:0] in_dividend = '0;
  logic [15:0] in_divisor = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_quotient;
  logic [15:0] out_remainder;
  logic [7:0]  out_tag;
  logic        out_div_zero;
  logic        out_overflow;

  // W=8 instance
  logic        d8_in_valid = 1'b0, d8_in_ready, d8_in_signed = 1'b0;
  logic [7:0]  d8_in_dividend = '0, d8_in_divisor = '0;
  logic [0:0]  d8_in_tag = '0, d8_out_tag;
  logic        d8_out_valid, d8_out_div_zero, d8_out_overflow;
  logic [7:0]  d8_out_quotient, d8_out_remainder;
  // W=32 instance
  logic        d32_in_valid = 1'b0, d32_in_ready, d32_in_signed = 1'b0;
  logic [31:0] d32_in_dividend = '0, d32_in_divisor = '0;
  logic [0:0]  d32_in_tag = '0, d32_out_tag;
  logic        d32_out_valid, d32_out_div_zero, d32_out_overflow;
  logic [31:0] d32_out_quotient, d32_out_remainder;
  logic        sw_ready = 1'b1;

  always #5 clk = ~clk;

  pipelined_divider_param #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_tag(out_tag),
    .out_div_zero(out_div_zero), .out_overflow(out_overflow)
  );

  pipelined_divider_param #(.W(8), .TAG_W(1)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready), .in_signed(d8_in_signed),
    .in_dividend(d8_in_dividend), .in_divisor(d8_in_divisor), .in_tag(d8_in_tag),
    .out_valid(d8_out_valid), .out_ready(sw_ready),
    .out_quotient(d8_out_quotient), .out_remainder(d8_out_remainder), .out_tag(d8_out_tag),
    .out_div_zero(d8_out_div_zero), .out_overflow(d8_out_overflow)
  );

  pipelined_divider_param #(.W(32), .TAG_W(1)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(d32_in_valid), .in_ready(d32_in_ready), .in_signed(d32_in_signed),
    .in_dividend(d32_in_dividend), .in_divisor(d32_in_divisor), .in_tag(d32_in_tag),
    .out_valid(d32_out_valid), .out_ready(sw_ready),
    .out_quotient(d32_out_quotient), .out_remainder(d32_out_remainder), .out_tag(d32_out_tag),
    .out_div_zero(d32_out_div_zero), .out_overflow(d32_out_overflow)
  );

  typedef struct {
    bit          s;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    logic [15:0] q;
    logic [15:0] r;
    bit          dz;
    bit          ov;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic [7:0]  tag;
    bit          dz;
    bit          ov;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   res_cnt = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Behavioural reference using the language's division operators.
  function automatic void model(input int w, input bit s, input longint unsigned a,
                                input longint unsigned b, output longint unsigned q,
                                output longint unsigned r, output bit dz, output bit ov);
    longint unsigned mask, top;
    longint sa, sbv;
    mask = (64'd1 << w) - 64'd1;
    top  = 64'd1 << (w - 1);
    q = 0; r = 0; dz = 0; ov = 0;
    if (b == 0) begin
      q = mask; r = a; dz = 1;
    end else if (s && a == top && b == mask) begin
      q = a; r = 0; ov = 1;
    end else if (s) begin
      sa  = ((a & top) != 0) ? $signed(a) - $signed(mask) - 64'sd1 : $signed(a);
      sbv = ((b & top) != 0) ? $signed(b) - $signed(mask) - 64'sd1 : $signed(b);
      q = $unsigned(sa / sbv) & mask;
      r = $unsigned(sa % sbv) & mask;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Monitor: handshake rule, output hold under backpressure, scoreboard.
  logic [42:0]     cur_snap, hold_snap;
  bit              hold_armed = 0;
  exp_t            mon_e;
  longint unsigned mq, mr;
  bit              mdz, mov;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_armed = 0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      cur_snap = {out_valid, out_quotient, out_remainder, out_tag, out_div_zero, out_overflow};
      if (hold_armed) check("hold_stable", 64'(cur_snap), 64'(hold_snap));
      hold_armed = out_valid && !out_ready;
      hold_snap  = cur_snap;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_result got tag=%h expected=no result", out_tag);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result", 64'({out_quotient, out_remainder, out_tag, out_div_zero, out_overflow}),
                64'({mon_e.q, mon_e.r, mon_e.tag, mon_e.dz, mon_e.ov}));
          res_cnt++;
          $display("result tag=%h q=%h r=%h dz=%0d ov=%0d", out_tag, out_quotient,
                   out_remainder, out_div_zero, out_overflow);
        end
      end
      if (in_valid && in_ready) begin
        model(16, in_signed, 64'(in_dividend), 64'(in_divisor), mq, mr, mdz, mov);
        mon_e.q = mq[15:0]; mon_e.r = mr[15:0]; mon_e.tag = in_tag;
        mon_e.dz = mdz; mon_e.ov = mov;
        sb_q.push_back(mon_e);
        acc_cnt++;
      end
    end
  end

  // One isolated operation on the W=16 instance; checks latency and result.
  task automatic run_vec(input vec_t v);
    int n;
    @(posedge clk); #1;
    in_valid = 1; in_signed = v.s; in_dividend = v.a; in_divisor = v.b; in_tag = v.tag;
    @(posedge clk); #1;
    in_valid = 0; n = 1;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    check("vec_latency", 64'(n), 64'(W + 2));
    check("vec_result", 64'({out_quotient, out_remainder, out_tag, out_div_zero, out_overflow}),
          64'({v.q, v.r, v.tag, v.dz, v.ov}));
  endtask

  // One isolated operation on the W=8 or W=32 instance.
  task automatic run_sweep(input int w, input bit s, input longint unsigned a,
                           input longint unsigned b, input bit tg,
                           output longint unsigned gq, output bit gov);
    longint unsigned eq, er;
    bit edz, eov;
    int n;
    model(w, s, a, b, eq, er, edz, eov);
    @(posedge clk); #1;
    if (w == 8) begin
      check("w8_in_ready", 64'(d8_in_ready), 64'd1);
      d8_in_valid = 1; d8_in_signed = s; d8_in_dividend = a[7:0]; d8_in_divisor = b[7:0]; d8_in_tag = tg;
    end else begin
      check("w32_in_ready", 64'(d32_in_ready), 64'd1);
      d32_in_valid = 1; d32_in_signed = s; d32_in_dividend = a[31:0]; d32_in_divisor = b[31:0]; d32_in_tag = tg;
    end
    @(posedge clk); #1;
    d8_in_valid = 0; d32_in_valid = 0; n = 1;
    while (!((w == 8) ? d8_out_valid : d32_out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    check("sweep_latency", 64'(n), 64'(w + 2));
    if (w == 8) begin
      gq = 64'(d8_out_quotient); gov = d8_out_overflow;
      check("w8_q", 64'(d8_out_quotient), eq);
      check("w8_r", 64'(d8_out_remainder), er);
      check("w8_tag_flags", 64'({d8_out_tag, d8_out_div_zero, d8_out_overflow}), 64'({tg, edz, eov}));
    end else begin
      gq = 64'(d32_out_quotient); gov = d32_out_overflow;
      check("w32_q", 64'(d32_out_quotient), eq);
      check("w32_r", 64'(d32_out_remainder), er);
      check("w32_tag_flags", 64'({d32_out_tag, d32_out_div_zero, d32_out_overflow}), 64'({tg, edz, eov}));
    end
  endtask

  task automatic rand_drive();
    int k;
    k = $urandom_range(0, 9);
    in_signed   = 1'($urandom_range(0, 1));
    in_dividend = 16'($urandom);
    in_divisor  = 16'($urandom);
    in_tag      = 8'($urandom);
    case (k)
      0: in_divisor = 16'h0000;
      1: begin in_signed = 1; in_dividend = 16'h8000; in_divisor = 16'hFFFF; end
      2: in_divisor = 16'hFFFF;
      3, 4: in_divisor = 16'($urandom_range(1, 15));
      default: ;
    endcase
  endtask

  vec_t            vecs[16];
  longint unsigned gq;
  bit              gov;
  int              n, seen, cyc, start_acc, start_res;

  initial begin
    // Expected values worked out by hand from truncating division.
    vecs[0]  = '{0, 16'd100,   16'd7,     8'h5A, 16'd14,    16'd2,     0, 0};
    vecs[1]  = '{0, 16'hFFFF,  16'd1,     8'h01, 16'hFFFF,  16'h0000,  0, 0};
    vecs[2]  = '{1, 16'hFF9C,  16'd7,     8'h02, 16'hFFF2,  16'hFFFE,  0, 0};
    vecs[3]  = '{1, 16'd100,   16'hFFF9,  8'h03, 16'hFFF2,  16'h0002,  0, 0};
    vecs[4]  = '{1, 16'hFF9C,  16'hFFF9,  8'h04, 16'h000E,  16'hFFFE,  0, 0};
    vecs[5]  = '{0, 16'hFF9C,  16'd7,     8'h05, 16'h2484,  16'h0000,  0, 0};
    vecs[6]  = '{0, 16'd1234,  16'd0,     8'h06, 16'hFFFF,  16'd1234,  1, 0};
    vecs[7]  = '{1, 16'h8000,  16'hFFFF,  8'h07, 16'h8000,  16'h0000,  0, 1};
    vecs[8]  = '{1, 16'h8000,  16'h0000,  8'h08, 16'hFFFF,  16'h8000,  1, 0};
    vecs[9]  = '{1, 16'hFFFF,  16'h0000,  8'h09, 16'hFFFF,  16'hFFFF,  1, 0};
    vecs[10] = '{1, 16'h8000,  16'h0001,  8'h0A, 16'h8000,  16'h0000,  0, 0};
    vecs[11] = '{0, 16'h8000,  16'hFFFF,  8'h0B, 16'h0000,  16'h8000,  0, 0};
    vecs[12] = '{1, 16'h7FFF,  16'h8000,  8'h0C, 16'h0000,  16'h7FFF,  0, 0};
    vecs[13] = '{0, 16'hFFFF,  16'hFFFF,  8'h0D, 16'h0001,  16'h0000,  0, 0};
    vecs[14] = '{0, 16'hFFFF,  16'h8001,  8'h0E, 16'h0001,  16'h7FFE,  0, 0};
    vecs[15] = '{1, 16'h8000,  16'h8000,  8'h0F, 16'h0001,  16'h0000,  0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1; rst = 0;
    check("reset_outputs", 64'({out_valid, out_quotient, out_remainder, out_tag, out_div_zero, out_overflow}), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_sweep_valid", 64'({d8_out_valid, d32_out_valid}), 64'd0);

    // Directed table
    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset mid-flight: five ops in flight, reset on the sixth cycle
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_signed = 0; in_dividend = 16'(1000 + i); in_divisor = 16'd3; in_tag = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    rst = 1; in_tag = 8'h85;
    @(posedge clk); #1;
    rst = 0;
    check("midreset_outputs", 64'({out_valid, out_quotient, out_remainder, out_tag, out_div_zero, out_overflow}), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1; in_signed = 0; in_dividend = 16'd100; in_divisor = 16'd7; in_tag = 8'h33;
    @(posedge clk); #1;
    in_valid = 0; n = 1;
    while (!out_valid && n < 60) begin @(posedge clk); #1; n++; end
    check("post_reset_latency", 64'(n), 64'(W + 2));
    check("post_reset_result", 64'({out_quotient, out_remainder, out_tag}), 64'({16'd14, 16'd2, 8'h33}));
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("post_reset_extra_results", 64'(seen), 64'd0);

    // Random streaming with backpressure
    start_acc = acc_cnt; start_res = res_cnt; cyc = 0;
    while ((acc_cnt - start_acc) < 200 && cyc < 5000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      rand_drive();
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 0;
    check("stream_accepted", 64'(acc_cnt - start_acc), 64'd200);
    out_ready = 1; cyc = 0;
    while (sb_q.size() != 0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    check("stream_drained", 64'(sb_q.size()), 64'd0);
    check("stream_results", 64'(res_cnt - start_res), 64'd200);

    // Parameter sweep
    run_sweep(8, 0, 100, 7, 1, gq, gov);
    run_sweep(8, 1, 'h80, 'hFF, 0, gq, gov);
    check("w8_ovf_q_const", gq, 64'h80);
    check("w8_ovf_flag_const", 64'(gov), 64'd1);
    run_sweep(8, 0, 'h12, 0, 1, gq, gov);
    run_sweep(8, 1, 'h9C, 7, 0, gq, gov);
    run_sweep(32, 0, 100, 7, 1, gq, gov);
    run_sweep(32, 1, 'h80000000, 'hFFFFFFFF, 0, gq, gov);
    check("w32_ovf_q_const", gq, 64'h80000000);
    check("w32_ovf_flag_const", 64'(gov), 64'd1);
    run_sweep(32, 0, 1234, 0, 1, gq, gov);
    run_sweep(32, 0, 'hFFFFFFFF, 1, 0, gq, gov);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
